intra_edge_upsample: RTL

Streaming AV1 intra edge upsampler: consumes the registered `useUpsample` decision together with one edge (above row or left column) and produces the 2x upsampled edge used by directional prediction. It buffers the `numPx+1` original samples `orig[-1..numPx-1]` and then emits `2*numPx+1` samples in the spec's `buf[-2..2*numPx-2]` order. It sits between the edge-preparation/filter stage and the directional predictor.

---
 rtl/intra_edge_upsample.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/intra_edge_upsample.sv
// Streaming AV1 intra edge 2x upsampler: buffers orig[-1..n-1], then emits the interleaved upsampled edge.
// Optional INTRA_EDGE_UPSAMPLE_BYPASS_EN: useUpsample=0 jobs pass the edge through unchanged instead of being skipped.
module intra_edge_upsample #(
  parameter int BIT_DEPTH = 10,
  parameter int MAX_NUMPX = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 useUpsample,
  input  logic [4:0]           numPx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_DEPTH-1:0] in_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_DEPTH-1:0] out_sample,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(MAX_NUMPX + 1);
  localparam int CW = $clog2(MAX_NUMPX + 3);
  localparam int BW = $clog2(2 * MAX_NUMPX + 2);
  localparam int SW = BIT_DEPTH + 6;

`ifdef INTRA_EDGE_UPSAMPLE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t                 state, state_next;
  logic                   use_up;
  logic [CW-1:0]          n;
  logic [CW-1:0]          n_sat;
  logic [CW-1:0]          wr_cnt;
  logic [BW-1:0]          beat;
  logic [BW-1:0]          sel_idx;
  logic [BW-1:0]          last_idx;
  logic [BIT_DEPTH-1:0]   mem [0:MAX_NUMPX];
  logic                   in_fire, fill_last, out_fire;

  logic [CW-1:0]          half, ia, ib, ic, id;
  logic signed [SW-1:0]   a, b, c, d, acc, shifted;
  logic [BIT_DEPTH-1:0]   interp, next_sample;

  assign n_sat     = (int'(numPx) > MAX_NUMPX) ? CW'(MAX_NUMPX) : CW'(numPx);
  assign in_ready  = (state == FILL);
  assign busy      = (state != IDLE);
  assign in_fire   = (state == FILL) && in_valid;
  assign fill_last = in_fire && (wr_cnt == n);
  assign out_fire  = (state == EMIT) && out_valid && out_ready;
  assign sel_idx   = (state == FILL) ? '0 : beat + 1'b1;
  assign last_idx  = use_up ? BW'({n, 1'b0}) : BW'(n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_sat == '0)                 state_next = DONE;
          else if (!useUpsample && !BYPASS) state_next = DONE;
          else                              state_next = FILL;
        end
      end
      FILL:    if (fill_last) state_next = EMIT;
      EMIT:    if (out_fire && out_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Odd beats are the 4-tap half-sample interpolation between mem[half] and mem[half+1],
  // with taps clamped to the buffered range [0, n].
  always_comb begin
    half = CW'(sel_idx >> 1);
    ia   = (half == '0) ? '0 : half - 1'b1;
    ib   = half;
    ic   = half + 1'b1;
    id   = ((half + CW'(2)) > n) ? n : half + CW'(2);
    a    = $signed(SW'(mem[ia[AW-1:0]]));
    b    = $signed(SW'(mem[ib[AW-1:0]]));
    c    = $signed(SW'(mem[ic[AW-1:0]]));
    d    = $signed(SW'(mem[id[AW-1:0]]));
    acc  = (b <<< 3) + b + (c <<< 3) + c - a - d + $signed(SW'(8));
    shifted = acc >>> 4;
    if (shifted[SW-1])                  interp = '0;
    else if (|shifted[SW-2:BIT_DEPTH])  interp = '1;
    else                                interp = shifted[BIT_DEPTH-1:0];
    if (!use_up)         next_sample = mem[sel_idx[AW-1:0]];
    else if (sel_idx[0]) next_sample = interp;
    else                 next_sample = mem[ib[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_cnt[AW-1:0]] <= in_sample;
  end

  // The output register is preloaded on the last input handshake so beat 0 is valid right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      use_up     <= 1'b0;
      n          <= '0;
      wr_cnt     <= '0;
      beat       <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          wr_cnt <= '0;
          if (start) begin
            use_up <= useUpsample;
            n      <= n_sat;
          end
        end
        FILL: begin
          if (in_fire) wr_cnt <= wr_cnt + 1'b1;
          if (fill_last) begin
            out_valid  <= 1'b1;
            out_sample <= next_sample;
            out_last   <= (sel_idx == last_idx);
            beat       <= '0;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_sample <= next_sample;
              out_last   <= (sel_idx == last_idx);
              beat       <= sel_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
